// File: rtl/uart_io_pkg.sv
// Shared constants and state encodings for the UART IO bridge.
package uart_io_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ERR_W  = 5;

  localparam int unsigned ERR_FRAME    = 0;
  localparam int unsigned ERR_RX_OVF   = 1;
  localparam int unsigned ERR_TX_STALL = 2;
  localparam int unsigned ERR_GLITCH   = 3;

  localparam int unsigned STALL_W = 20;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_io_bridge_if.sv
// Core-side IO handshake bundle: byte stream out, byte stream in, error flags.
interface uart_io_bridge_if;
  import uart_io_pkg::*;

  logic [BYTE_W-1:0] io_out_data;
  logic              io_out_vld;
  logic              io_out_rdy;
  logic [BYTE_W-1:0] io_in_data;
  logic              io_in_vld;
  logic              io_in_rdy;
  logic [ERR_W-1:0]  io_err;

  modport master (
    output io_out_data, io_out_vld, io_in_rdy,
    input  io_out_rdy, io_in_data, io_in_vld, io_err
  );

  modport slave (
    input  io_out_data, io_out_vld, io_in_rdy,
    output io_out_rdy, io_in_data, io_in_vld, io_err
  );

endinterface

// File: rtl/uart_io_bridge_fifo.sv
// First-word-fall-through synchronous FIFO with registered full/empty flags.
module sync_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;

  always_comb cnt_nxt = cnt + (AW+1)'(push) - (AW+1)'(pop);

  // full reads 1 while in reset so producers see no space until reset is released
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b1;
      empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/uart_io_bridge.sv
// Bridges the core IO byte handshakes to an 8N1 UART with TX/RX FIFOs
// and sticky line/buffer error flags.
module uart_io_bridge
  import uart_io_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned FIFO_AW     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  uart_io_bridge_if.slave  io,
  input  logic             uart_rxd,
  output logic             uart_txd
);

  localparam int unsigned      CW        = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0]    BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0]    BIT_HALF  = CW'(CLK_PER_BIT / 2);
  localparam int unsigned      STALL_CW  = STALL_W + 1;
  localparam logic [STALL_CW-1:0] STALL_LIM = STALL_CW'(1) << STALL_W;

  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [BYTE_W-1:0] tx_head;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [BYTE_W-1:0] rx_head;

  tx_state_e         tx_state, tx_state_nxt;
  logic [CW-1:0]     tx_cnt, tx_cnt_nxt;
  logic [2:0]        tx_idx, tx_idx_nxt;
  logic [BYTE_W-1:0] tx_sh, tx_sh_nxt;
  logic              txd_nxt;

  rx_state_e         rx_state, rx_state_nxt;
  logic [CW-1:0]     rx_cnt, rx_cnt_nxt;
  logic [2:0]        rx_idx, rx_idx_nxt;
  logic [BYTE_W-1:0] rx_sh, rx_sh_nxt;
  logic              rxd_meta, rxd_sync, rxd_prev;

  logic [ERR_W-1:0]    err, err_nxt;
  logic [STALL_CW-1:0] stall_cnt, stall_cnt_nxt;
  logic                tx_stall;

  assign tx_push        = io.io_out_vld & io.io_out_rdy;
  assign rx_pop         = io.io_in_vld & io.io_in_rdy;
  assign io.io_out_rdy  = ~tx_full;
  assign io.io_in_vld   = ~rx_empty;
  assign io.io_in_data  = rx_head;
  assign io.io_err      = err;

  sync_fifo #(.W(BYTE_W), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(tx_push), .push_data(io.io_out_data),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.W(BYTE_W), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(rx_push), .push_data(rx_sh),
    .pop(rx_pop), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Transmitter: txd is registered alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_idx   <= tx_idx_nxt;
      tx_sh    <= tx_sh_nxt;
      uart_txd <= txd_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_idx_nxt   = tx_idx;
    tx_sh_nxt    = tx_sh;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop       = 1'b1;
          tx_sh_nxt    = tx_head;
          tx_cnt_nxt   = '0;
          tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        tx_cnt_nxt = tx_cnt + CW'(1);
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_idx_nxt   = '0;
          tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_cnt_nxt = tx_cnt + CW'(1);
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt = '0;
          tx_sh_nxt  = tx_sh >> 1;
          tx_idx_nxt = tx_idx + 3'd1;
          if (tx_idx == 3'd7) tx_state_nxt = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_cnt_nxt = tx_cnt + CW'(1);
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = TX_IDLE;
          // Chain straight into the next start bit when a byte is waiting
          if (!tx_empty) begin
            tx_pop       = 1'b1;
            tx_sh_nxt    = tx_head;
            tx_state_nxt = TX_START;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
    case (tx_state_nxt)
      TX_START: txd_nxt = 1'b0;
      TX_DATA:  txd_nxt = tx_sh_nxt[0];
      default:  txd_nxt = 1'b1;
    endcase
  end

  // Receiver state, synchroniser and sticky error flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rxd_prev  <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_sh     <= '0;
      err       <= '0;
      stall_cnt <= '0;
    end else begin
      rxd_meta  <= uart_rxd;
      rxd_sync  <= rxd_meta;
      rxd_prev  <= rxd_sync;
      rx_state  <= rx_state_nxt;
      rx_cnt    <= rx_cnt_nxt;
      rx_idx    <= rx_idx_nxt;
      rx_sh     <= rx_sh_nxt;
      err       <= err_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  always_comb begin
    rx_state_nxt  = rx_state;
    rx_cnt_nxt    = rx_cnt;
    rx_idx_nxt    = rx_idx;
    rx_sh_nxt     = rx_sh;
    rx_push       = 1'b0;
    err_nxt       = err;
    tx_stall      = io.io_out_vld & ~io.io_out_rdy;
    stall_cnt_nxt = '0;
    case (rx_state)
      RX_IDLE: begin
        if (rxd_prev && !rxd_sync) begin
          rx_cnt_nxt   = BIT_HALF;
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        rx_cnt_nxt = rx_cnt + CW'(1);
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt = '0;
          rx_idx_nxt = '0;
          if (rxd_sync) begin
            err_nxt[ERR_GLITCH] = 1'b1;
            rx_state_nxt        = RX_IDLE;
          end else begin
            rx_state_nxt = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        rx_cnt_nxt = rx_cnt + CW'(1);
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt = '0;
          rx_sh_nxt  = {rxd_sync, rx_sh[BYTE_W-1:1]};
          rx_idx_nxt = rx_idx + 3'd1;
          if (rx_idx == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_nxt = rx_cnt + CW'(1);
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt = '0;
          if (!rxd_sync) begin
            err_nxt[ERR_FRAME] = 1'b1;
            rx_state_nxt       = RX_WAIT_HIGH;
          end else begin
            rx_state_nxt = RX_IDLE;
            if (!rx_full || rx_pop) rx_push = 1'b1;
            else                    err_nxt[ERR_RX_OVF] = 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rxd_sync) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
    // Stuck-core watchdog: flag once the core has pushed into a full FIFO too long
    if (tx_stall) begin
      stall_cnt_nxt = (stall_cnt == STALL_LIM) ? stall_cnt : stall_cnt + STALL_CW'(1);
      if (stall_cnt == STALL_LIM) err_nxt[ERR_TX_STALL] = 1'b1;
    end
    err_nxt[ERR_W-1] = 1'b0;
  end

endmodule

// File: tb/tb_uart_io_bridge.sv
// Directed scoreboard bench for uart_io_bridge (CLK_PER_BIT=4, FIFO_AW=2).
module tb_uart_io_bridge;
  import uart_io_pkg::*;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 2;

  logic clk      = 1'b0;
  logic rstn     = 1'b0;
  logic uart_rxd = 1'b1;
  logic uart_txd;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  logic [7:0] bp_bytes [6];
  int         bp_idx, bp_run, s_prev, s_cur, lows, mid_start;
  logic       bp_stalled, hs, found;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_io_bridge_if io();

  uart_io_bridge #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .rstn(rstn), .io(io.slave), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Core-style push: hold vld until the handshake edge, then drop it
  task automatic push_byte(input logic [7:0] b);
    logic ok = 1'b0;
    logic h;
    io.io_out_data = b;
    io.io_out_vld  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      h = io.io_out_rdy;
      tick();
      if (h) begin
        ok = 1'b1;
        break;
      end
    end
    io.io_out_vld = 1'b0;
    if (ok) tx_q.push_back(b);
    check("push_accepted", 32'(ok), 32'(1));
  endtask

  // Decode one 8N1 frame on txd and compare it against the scoreboard head
  task automatic tx_frame_check(input string tag, output int start);
    logic [7:0] b = '0;
    logic [7:0] exp;
    logic       seen = 1'b0;
    start = -1;
    for (int i = 0; i < 300; i++) begin
      if (uart_txd === 1'b0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_start_seen"}, 32'(seen), 32'(1));
    if (seen) begin
      start = cyc;
      tick(2);
      check({tag, "_start_mid"}, 32'(uart_txd), 32'(0));
      for (int k = 0; k < 8; k++) begin
        tick(CPB);
        b[k] = uart_txd;
      end
      tick(CPB);
      check({tag, "_stop"}, 32'(uart_txd), 32'(1));
      exp = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
      check({tag, "_byte"}, 32'(b), 32'(exp));
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int k = 0; k < 8; k++) begin
      uart_rxd = b[k];
      tick(CPB);
    end
    uart_rxd = stop;
    tick(CPB);
    uart_rxd = 1'b1;
  endtask

  // Wait briefly for a received byte, compare with scoreboard, pop it with a 1-cycle rdy
  task automatic pop_check(input string tag);
    logic ok = 1'b0;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      if (io.io_in_vld === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_vld"}, 32'(ok), 32'(1));
    if (ok) begin
      exp = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      check({tag, "_data"}, 32'(io.io_in_data), 32'(exp));
      io.io_in_rdy = 1'b1;
      tick();
      io.io_in_rdy = 1'b0;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick();
    tx_q.delete();
    rx_q.delete();
  endtask

  initial begin
    io.io_out_data = '0;
    io.io_out_vld  = 1'b0;
    io.io_in_rdy   = 1'b0;
    bp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset values
    tick(2);
    check("rst_txd", 32'(uart_txd), 32'(1));
    check("rst_out_rdy", 32'(io.io_out_rdy), 32'(0));
    check("rst_in_vld", 32'(io.io_in_vld), 32'(0));
    check("rst_in_data", 32'(io.io_in_data), 32'(0));
    check("rst_err", 32'(io.io_err), 32'(0));
    rstn = 1'b1;
    tick();
    check("post_rst_out_rdy", 32'(io.io_out_rdy), 32'(1));

    // Single TX with latency
    push_byte(8'hA5);
    check("tx_lat_t1", 32'(uart_txd), 32'(1));
    tick();
    check("tx_lat_t2", 32'(uart_txd), 32'(0));
    tx_frame_check("tx_a5", s_cur);
    check("tx_a5_err", 32'(io.io_err), 32'(0));
    tick(4);

    // TX backpressure: continuous stream, decoder runs alongside
    bp_idx = 0;
    bp_run = 0;
    bp_stalled = 1'b0;
    fork
      begin
        io.io_out_vld = 1'b1;
        for (int c = 0; c < 400 && bp_idx < 6; c++) begin
          io.io_out_data = bp_bytes[bp_idx];
          hs = io.io_out_rdy;
          tick();
          if (hs) begin
            tx_q.push_back(bp_bytes[bp_idx]);
            bp_idx++;
            if (!bp_stalled) bp_run++;
          end else begin
            bp_stalled = 1'b1;
          end
        end
        io.io_out_vld = 1'b0;
      end
      begin
        for (int f = 0; f < 6; f++) begin
          tx_frame_check($sformatf("bp%0d", f), s_cur);
          if (f > 0) check($sformatf("bp_gap%0d", f), 32'(s_cur - s_prev), 32'(10 * CPB));
          s_prev = s_cur;
        end
      end
    join
    check("bp_all_pushed", 32'(bp_idx), 32'(6));
    check("bp_run_before_stall", 32'(bp_run), 32'(5));
    check("bp_err", 32'(io.io_err), 32'(0));

    // Single RX
    send_frame(8'h3C, 1'b1);
    rx_q.push_back(8'h3C);
    pop_check("rx_3c");
    check("rx_3c_drained", 32'(io.io_in_vld), 32'(0));

    // RX overflow: five frames, no pops
    for (int f = 0; f < 5; f++) begin
      send_frame(8'(f + 1), 1'b1);
      if (f < 4) rx_q.push_back(8'(f + 1));
    end
    tick(3);
    check("ovf_err", 32'(io.io_err), 32'(5'b00010));
    for (int f = 0; f < 4; f++) pop_check($sformatf("ovf%0d", f));
    check("ovf_drained", 32'(io.io_in_vld), 32'(0));

    do_reset();
    check("rst2_err", 32'(io.io_err), 32'(0));

    // Framing error
    send_frame(8'h5A, 1'b0);
    tick(3);
    check("frame_err", 32'(io.io_err), 32'(5'b00001));
    check("frame_no_push", 32'(io.io_in_vld), 32'(0));

    // Start glitch
    uart_rxd = 1'b0;
    tick();
    uart_rxd = 1'b1;
    tick(8);
    check("glitch_err", 32'(io.io_err), 32'(5'b01001));
    check("glitch_no_push", 32'(io.io_in_vld), 32'(0));

    // Break longer than a whole frame, then a clean byte
    uart_rxd = 1'b0;
    tick(60);
    uart_rxd = 1'b1;
    tick(4);
    check("break_err", 32'(io.io_err), 32'(5'b01001));
    check("break_no_push", 32'(io.io_in_vld), 32'(0));
    send_frame(8'h55, 1'b1);
    rx_q.push_back(8'h55);
    pop_check("rx_55");

    // Reset in the middle of a TX frame with both FIFOs occupied
    send_frame(8'h11, 1'b1);
    tick(2);
    check("mid_pre_rx_vld", 32'(io.io_in_vld), 32'(1));
    push_byte(8'h96);
    push_byte(8'h69);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (uart_txd === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("mid_start_seen", 32'(found), 32'(1));
    mid_start = cyc;
    tick(4 * CPB + 1);
    check("mid_in_bit3", 32'(cyc - mid_start), 32'(4 * CPB + 1));
    rstn = 1'b0;
    tick();
    check("mid_rst_txd", 32'(uart_txd), 32'(1));
    check("mid_rst_out_rdy", 32'(io.io_out_rdy), 32'(0));
    check("mid_rst_in_vld", 32'(io.io_in_vld), 32'(0));
    check("mid_rst_in_data", 32'(io.io_in_data), 32'(0));
    check("mid_rst_err", 32'(io.io_err), 32'(0));
    tick();
    rstn = 1'b1;
    tick();
    check("mid_post_out_rdy", 32'(io.io_out_rdy), 32'(1));
    tx_q.delete();
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (uart_txd !== 1'b1) lows++;
      tick();
    end
    check("mid_tx_fifo_flushed", 32'(lows), 32'(0));
    check("mid_rx_fifo_flushed", 32'(io.io_in_vld), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
